usb_rx_bit_unstuff: RTL and testbench

- Receive-side stage of the USB 1.1 PHY path, downstream of the line sampler/SYNC detector.
- Takes serial decoded bits qualified by a strobe, removes stuffed bits, detects stuff errors, and assembles bytes LSB-first.
- Outputs bytes with a one-cycle valid pulse to the packet decoder, plus EOP and error indications.

---
 rtl/usb_rx_bit_unstuff_if.sv | 26 ++
 rtl/usb_rx_bit_unstuff.sv | 133 +++++++++++++
 tb/tb_usb_rx_bit_unstuff.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_bit_unstuff_if.sv
// rtl/usb_rx_bit_unstuff_if.sv - Bit strobe in / byte and status out bundle for the USB RX unstuffer
interface usb_rx_bit_unstuff_if #(
  parameter int CNT_W = 11
);
  logic             rx_en;
  logic             bit_valid;
  logic             bit_in;
  logic             se0;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             rx_active;
  logic             eop;
  logic             stuff_err;
  logic             byte_err;
  logic [CNT_W-1:0] byte_cnt;

  modport master (
    output rx_en, bit_valid, bit_in, se0,
    input  data_out, data_valid, rx_active, eop, stuff_err, byte_err, byte_cnt
  );

  modport slave (
    input  rx_en, bit_valid, bit_in, se0,
    output data_out, data_valid, rx_active, eop, stuff_err, byte_err, byte_cnt
  );
endinterface

// File: rtl/usb_rx_bit_unstuff.sv
// rtl/usb_rx_bit_unstuff.sv - USB 1.1 RX bit unstuffer, stuff-error check and LSB-first byte assembler
// Define USB_RX_NRZI_EN to accept raw line levels and NRZI-decode them here.
module usb_rx_bit_unstuff #(
  parameter int MAX_ONES = 6,
  parameter int CNT_W    = 11
) (
  input logic                 clk,
  input logic                 rst,
  usb_rx_bit_unstuff_if.slave bus
);

  localparam int OW = $clog2(MAX_ONES + 1);

  typedef enum logic [1:0] {IDLE, RECV, ERR} state_e;

  state_e           state_q;
  logic [OW-1:0]    ones_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [6:0]       shreg_q;
  logic [7:0]       data_out_q;
  logic             data_valid_q;
  logic             rx_active_q;
  logic             eop_q;
  logic             stuff_err_q;
  logic             byte_err_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             dbit_d;

`ifdef USB_RX_NRZI_EN
  // No transition on the line (same level as last bit) decodes as a 1.
  logic last_lvl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lvl_q <= 1'b1;
    end else if (bus.bit_valid) begin
      last_lvl_q <= bus.bit_in;
    end
  end

  assign dbit_d = (bus.bit_in == last_lvl_q);
`else
  assign dbit_d = bus.bit_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ones_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      rx_active_q  <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
      byte_err_q   <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      data_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
      byte_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_en) begin
            state_q     <= RECV;
            rx_active_q <= 1'b1;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_cnt_q  <= '0;
          end
        end
        RECV: begin
          // EOP wins over a coincident bit; that bit is dropped.
          if (bus.se0) begin
            eop_q       <= 1'b1;
            byte_err_q  <= (bit_cnt_q != 3'd0);
            state_q     <= IDLE;
            rx_active_q <= 1'b0;
          end else if (!bus.rx_en) begin
            state_q     <= IDLE;
            rx_active_q <= 1'b0;
          end else if (bus.bit_valid) begin
            if (ones_cnt_q == OW'(MAX_ONES)) begin
              if (dbit_d) begin
                stuff_err_q <= 1'b1;
                state_q     <= ERR;
              end else begin
                ones_cnt_q  <= '0;
              end
            end else begin
              shreg_q    <= {dbit_d, shreg_q[6:1]};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              ones_cnt_q <= dbit_d ? ones_cnt_q + OW'(1) : '0;
              if (bit_cnt_q == 3'd7) begin
                data_out_q   <= {dbit_d, shreg_q};
                data_valid_q <= 1'b1;
                if (byte_cnt_q != '1) begin
                  byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                end
              end
            end
          end
        end
        ERR: begin
          if (bus.se0) begin
            eop_q       <= 1'b1;
            state_q     <= IDLE;
            rx_active_q <= 1'b0;
          end else if (!bus.rx_en) begin
            state_q     <= IDLE;
            rx_active_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rx_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rx_active  = rx_active_q;
  assign bus.eop        = eop_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.byte_err   = byte_err_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_usb_rx_bit_unstuff.sv
// tb/tb_usb_rx_bit_unstuff.sv - Table-driven bench for usb_rx_bit_unstuff
module tb_usb_rx_bit_unstuff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic tb_lvl = 1'b1;

  always #5 clk = ~clk;

  usb_rx_bit_unstuff_if #(.CNT_W(11)) bus ();

  usb_rx_bit_unstuff #(.MAX_ONES(6), .CNT_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected word: {rx_active, data_valid, eop, stuff_err, byte_err, data_out[7:0], byte_cnt[10:0]}
  typedef struct {
    logic        en;
    logic        bv;
    logic        b;
    logic        se0;
    logic [23:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [23:0] observed();
    return {bus.rx_active, bus.data_valid, bus.eop, bus.stuff_err, bus.byte_err,
            bus.data_out, bus.byte_cnt};
  endfunction

  task automatic add(input logic en, bv, b, se0, act, dv, eop, serr, berr,
                     input logic [7:0] dout, input logic [10:0] cnt);
    vec_t v;
    v.en = en; v.bv = bv; v.b = b; v.se0 = se0;
    v.exp = {act, dv, eop, serr, berr, dout, cnt};
    vq.push_back(v);
  endtask

  task automatic addb(input logic b, input logic [7:0] dout, input logic [10:0] cnt);
    add(1'b1, 1'b1, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dout, cnt);
  endtask

  task automatic add_byte(input logic [7:0] val, input logic [7:0] prev_dout,
                          input logic [10:0] prev_cnt);
    for (int i = 0; i < 7; i++) addb(val[i], prev_dout, prev_cnt);
    add(1'b1, 1'b1, val[7], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, val, prev_cnt + 11'd1);
  endtask

  // Decoded bit -> line level when the DUT expects NRZI line levels.
  task automatic drive(input logic en, bv, b, se0);
    bus.rx_en     = en;
    bus.bit_valid = bv;
    bus.se0       = se0;
`ifdef USB_RX_NRZI_EN
    if (bv) tb_lvl = b ? tb_lvl : ~tb_lvl;
    bus.bit_in = tb_lvl;
`else
    bus.bit_in = b;
`endif
  endtask

  task automatic cyc(input logic en, bv, b, se0);
    drive(en, bv, b, se0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // 0xA5 then clean EOP
    add(1,0,0,0, 1,0,0,0,0, 8'h00, 11'd0);
    add_byte(8'hA5, 8'h00, 11'd0);
    add(1,0,0,1, 0,0,1,0,0, 8'hA5, 11'd1);
    add(0,0,0,0, 0,0,0,0,0, 8'hA5, 11'd1);

    // six 1s, stuffed 0, strobe gap, 1,1 -> 0xFF; then 0x00
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    for (int i = 0; i < 6; i++) addb(1'b1, 8'hA5, 11'd0);
    addb(1'b0, 8'hA5, 11'd0);
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    addb(1'b1, 8'hA5, 11'd0);
    add(1,1,1,0, 1,1,0,0,0, 8'hFF, 11'd1);
    add_byte(8'h00, 8'hFF, 11'd1);
    add(1,0,0,1, 0,0,1,0,0, 8'h00, 11'd2);
    add(0,0,0,0, 0,0,0,0,0, 8'h00, 11'd2);

    // seven 1s -> stuff error, later bits ignored, EOP without byte_err
    add(1,0,0,0, 1,0,0,0,0, 8'h00, 11'd0);
    for (int i = 0; i < 6; i++) addb(1'b1, 8'h00, 11'd0);
    add(1,1,1,0, 1,0,0,1,0, 8'h00, 11'd0);
    addb(1'b0, 8'h00, 11'd0);
    addb(1'b1, 8'h00, 11'd0);
    addb(1'b0, 8'h00, 11'd0);
    add(1,0,0,1, 0,0,1,0,0, 8'h00, 11'd0);
    add(0,0,0,0, 0,0,0,0,0, 8'h00, 11'd0);

    // 0xA5 then 3 bits, EOP with coincident bit -> byte_err
    add(1,0,0,0, 1,0,0,0,0, 8'h00, 11'd0);
    add_byte(8'hA5, 8'h00, 11'd0);
    addb(1'b1, 8'hA5, 11'd1);
    addb(1'b1, 8'hA5, 11'd1);
    addb(1'b0, 8'hA5, 11'd1);
    add(1,1,1,1, 0,0,1,0,1, 8'hA5, 11'd1);
    add(0,0,0,0, 0,0,0,0,0, 8'hA5, 11'd1);

    // se0 on the 8th bit -> no byte, eop + byte_err
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    addb(1'b0, 8'hA5, 11'd0); addb(1'b0, 8'hA5, 11'd0); addb(1'b1, 8'hA5, 11'd0);
    addb(1'b1, 8'hA5, 11'd0); addb(1'b1, 8'hA5, 11'd0); addb(1'b1, 8'hA5, 11'd0);
    addb(1'b0, 8'hA5, 11'd0);
    add(1,1,0,1, 0,0,1,0,1, 8'hA5, 11'd0);
    add(0,0,0,0, 0,0,0,0,0, 8'hA5, 11'd0);

    // rx_en dropped mid-byte -> silent abort
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    addb(1'b1, 8'hA5, 11'd0); addb(1'b0, 8'hA5, 11'd0); addb(1'b1, 8'hA5, 11'd0);
    add(0,1,1,0, 0,0,0,0,0, 8'hA5, 11'd0);
    add(0,0,0,0, 0,0,0,0,0, 8'hA5, 11'd0);

    // rx_en dropped on the 8th bit -> byte discarded
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    for (int i = 0; i < 7; i++) addb(1'b1 ^ i[0], 8'hA5, 11'd0);
    add(0,1,0,0, 0,0,0,0,0, 8'hA5, 11'd0);
    add(0,0,0,0, 0,0,0,0,0, 8'hA5, 11'd0);

    // ones run spans a byte boundary; stuffed 0 right before EOP
    add(1,0,0,0, 1,0,0,0,0, 8'hA5, 11'd0);
    add_byte(8'hF0, 8'hA5, 11'd0);
    addb(1'b1, 8'hF0, 11'd1);
    addb(1'b1, 8'hF0, 11'd1);
    addb(1'b0, 8'hF0, 11'd1);
    for (int i = 0; i < 5; i++) addb(1'b0, 8'hF0, 11'd1);
    add(1,1,0,0, 1,1,0,0,0, 8'h03, 11'd2);
    add_byte(8'hFC, 8'h03, 11'd2);
    addb(1'b0, 8'hFC, 11'd3);
    add(1,0,0,1, 0,0,1,0,0, 8'hFC, 11'd3);
    add(0,0,0,0, 0,0,0,0,0, 8'hFC, 11'd3);

    @(negedge clk);
    @(negedge clk);
    check("reset_state", observed(), 24'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].bv, vq[i].b, vq[i].se0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), observed(), vq[i].exp);
    end

    // byte_cnt saturation
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2047 * 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("cnt_at_2047", observed(), {5'b11000, 8'h00, 11'h7FF});
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("cnt_saturated", observed(), {5'b11000, 8'h00, 11'h7FF});
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat_eop", observed(), {5'b00100, 8'h00, 11'h7FF});

    // rst mid-packet, with se0 present, gives reset values and no eop
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tb_lvl = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_mid_packet", observed(), 24'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst_idle", observed(), 24'h0);

`ifdef USB_RX_NRZI_EN
    begin
      logic [7:0] lvls;
      lvls = 8'b1101_1100;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        bus.rx_en = 1'b1; bus.bit_valid = 1'b1; bus.se0 = 1'b0; bus.bit_in = lvls[i];
        @(posedge clk);
        @(negedge clk);
      end
      check("nrzi_9a", observed(), {5'b11000, 8'h9A, 11'd1});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
